// File: rtl/test_pkg.sv
// Shared packet, bus and writer types for the packet-to-bus path.
package test_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int WR_COUNT_W = 16;

  typedef logic [31:0] id_t;
  typedef logic [15:0] data_t;

  typedef struct packed {
    id_t   id;
    data_t data;
  } packet_t;

  typedef enum logic [1:0] {WR_IDLE, WR_ISSUE} writer_state_t;

endpackage

// File: rtl/bus_if.sv
// Simple valid/ready write bus between a master and a follower.
interface bus_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                   valid;
  logic                   ready;
  logic                   write_enable;
  logic [ADDR_WIDTH-1:0]  addr;
  test_pkg::data_t        data;

  modport master   (output valid, addr, data, write_enable, input ready);
  modport follower (input valid, addr, data, write_enable, output ready);
endinterface

// File: rtl/pkt_fifo.sv
// Synchronous FIFO with occupancy output; pushes while full and pops while empty are ignored.
module pkt_fifo #(
  parameter type T     = test_pkg::packet_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pkt_bus_writer.sv
// Buffers upstream packets and issues one bus write per packet (addr = id, data = data).
// Optional write-stall abort is enabled by defining PKT_BUS_WRITER_TIMEOUT_EN.
module pkt_bus_writer
  import test_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pkt_valid,
  output logic                        pkt_ready,
  input  packet_t                     pkt_in,
  bus_if.master                       bus_master,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [WR_COUNT_W-1:0]       wr_count,
  output logic                        timeout_err
);

  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  writer_state_t state;
  writer_state_t state_nxt;
  packet_t       head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          load;
  logic          clear;
  logic          inc;
  logic          tmo_fire;
  logic          timeout_hit;
  logic          handshake;

  pkt_fifo #(
    .T     (packet_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pkt_valid),
    .push_data (pkt_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign pkt_ready = !fifo_full;
  assign handshake = bus_master.valid && bus_master.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WR_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    inc       = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      WR_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (handshake) begin
          inc = 1'b1;
          // Chain straight into the next packet so a ready follower sees one write per cycle.
          if (!fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            clear     = 1'b1;
            state_nxt = WR_IDLE;
          end
        end else if (timeout_hit) begin
          tmo_fire  = 1'b1;
          clear     = 1'b1;
          state_nxt = WR_IDLE;
        end
      end
      default: state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_master.valid        <= 1'b0;
      bus_master.write_enable <= 1'b0;
      bus_master.addr         <= '0;
      bus_master.data         <= '0;
      wr_count                <= '0;
    end else begin
      if (load) begin
        bus_master.addr         <= head.id;
        bus_master.data         <= head.data;
        bus_master.valid        <= 1'b1;
        bus_master.write_enable <= 1'b1;
      end else if (clear) begin
        bus_master.valid        <= 1'b0;
        bus_master.write_enable <= 1'b0;
      end
      if (inc) wr_count <= sat_inc(wr_count);
    end
  end

`ifdef PKT_BUS_WRITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] stall_cnt;
  logic             stalled;

  assign stalled     = (state == WR_ISSUE) && !bus_master.ready;
  assign timeout_hit = stalled && (stall_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive refused cycles of the current write; any handshake restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
      if (stalled && !timeout_hit) stall_cnt <= stall_cnt + 1'b1;
      else                         stall_cnt <= '0;
    end
  end
`else
  logic unused_tmo_cfg;

  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_tmo_cfg = ^{TIMEOUT_CYCLES, tmo_fire};
`endif

endmodule

// File: tb/tb_pkt_bus_writer.sv
// Self-checking bench for pkt_bus_writer: directed scenarios plus a randomized stream.
module tb_pkt_bus_writer;
  import test_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;
`ifdef PKT_BUS_WRITER_TIMEOUT_EN
  localparam int STALL_CHECK = TMO - 1;
`else
  localparam int STALL_CHECK = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  packet_t     pkt_in = '0;
  logic [2:0]  fifo_level;
  logic [15:0] wr_count;
  logic        timeout_err;

  bus_if #(.ADDR_WIDTH(32)) bif ();

  pkt_bus_writer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_in      (pkt_in),
    .bus_master  (bif),
    .fifo_level  (fifo_level),
    .wr_count    (wr_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Passive recorder of completed writes, accepted packets and timeout pulses.
  packet_t obs_q[$];
  logic    obs_we[$];
  int      obs_cyc[$];
  packet_t acc_q[$];
  int      cyc = 0;
  int      tmo_pulses = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bif.valid && bif.ready) begin
        obs_q.push_back(packet_t'({bif.addr, bif.data}));
        obs_we.push_back(bif.write_enable);
        obs_cyc.push_back(cyc);
      end
      if (pkt_valid && pkt_ready) acc_q.push_back(pkt_in);
      if (timeout_err) tmo_pulses <= tmo_pulses + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; pkt_valid = 1'b0; bif.ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bif.ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (bif.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bif.valid); end
    checks++; if (bif.write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", bif.write_enable); end
    checks++; if (bif.addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bif.addr); end
    checks++; if (bif.data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bif.data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); end
    checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL reset_pkt_ready: got %0b want 1", pkt_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int ob;
    apply_reset();
    ob = obs_q.size();
    bif.ready = 1'b1;
    pkt_valid = 1'b1; pkt_in = packet_t'({32'h123, 16'h5678});
    @(negedge clk);
    pkt_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1 || bif.valid !== 1'b0) begin errors++; $display("FAIL single_latency: level %0d valid %0b want 1/0", fifo_level, bif.valid); end
    @(negedge clk);
    checks++; if (bif.valid !== 1'b1 || bif.write_enable !== 1'b1) begin errors++; $display("FAIL single_valid_we: got %0b/%0b want 1/1", bif.valid, bif.write_enable); end
    checks++; if (bif.addr !== 32'h123 || bif.data !== 16'h5678) begin errors++; $display("FAIL single_addr_data: got %h/%h want 123/5678", bif.addr, bif.data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_level: got %0d want 0", fifo_level); end
    @(negedge clk);
    checks++; if (bif.valid !== 1'b0 || wr_count !== 16'd1 || obs_q.size() - ob != 1) begin errors++; $display("FAIL single_done: valid %0b count %0d writes %0d want 0/1/1", bif.valid, wr_count, obs_q.size() - ob); end
  endtask

  task automatic test_back_to_back();
    packet_t exp[$];
    int ob;
    apply_reset();
    ob = obs_q.size();
    bif.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pkt_valid = 1'b1; pkt_in = packet_t'({32'(i), 16'($urandom)});
      exp.push_back(pkt_in);
      @(negedge clk);
    end
    pkt_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (obs_q.size() - ob != 4) begin errors++; $display("FAIL b2b_count: got %0d writes want 4", obs_q.size() - ob); end
    for (int i = 0; i < 4 && ob + i < obs_q.size(); i++) begin
      checks++; if (obs_q[ob+i] !== exp[i] || obs_we[ob+i] !== 1'b1) begin errors++; $display("FAIL b2b_write%0d: got %h we %0b want %h we 1", i, obs_q[ob+i], obs_we[ob+i], exp[i]); end
      if (i > 0) begin
        checks++; if (obs_cyc[ob+i] != obs_cyc[ob+i-1] + 1) begin errors++; $display("FAIL b2b_gap%0d: cycle %0d after %0d want consecutive", i, obs_cyc[ob+i], obs_cyc[ob+i-1]); end
      end
    end
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL b2b_wr_count: got %0d want 4", wr_count); end
  endtask

  task automatic test_full();
    packet_t exp[$];
    int ob;
    int ab;
    apply_reset();
    ob = obs_q.size(); ab = acc_q.size();
    bif.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before%0d: got %0b want 1", i, pkt_ready); end
      pkt_valid = 1'b1; pkt_in = packet_t'({$urandom, 16'($urandom)});
      exp.push_back(pkt_in);
      @(negedge clk);
    end
    checks++; if (pkt_ready !== 1'b0 || fifo_level !== 3'd4) begin errors++; $display("FAIL full_state: ready %0b level %0d want 0/4", pkt_ready, fifo_level); end
    checks++; if (bif.valid !== 1'b1 || bif.addr !== exp[0].id) begin errors++; $display("FAIL full_bus_head: valid %0b addr %h want 1/%h", bif.valid, bif.addr, exp[0].id); end
    pkt_in = packet_t'({32'hDEAD_BEEF, 16'hCAFE});
    @(negedge clk);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_refuse: level %0d want 4", fifo_level); end
    bif.ready = 1'b1;
    @(negedge clk);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_no_bypass: level %0d want 3", fifo_level); end
    pkt_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (obs_q.size() - ob != 5 || acc_q.size() - ab != 5) begin errors++; $display("FAIL full_counts: writes %0d accepted %0d want 5/5", obs_q.size() - ob, acc_q.size() - ab); end
    for (int i = 0; i < 5 && ob + i < obs_q.size(); i++) begin
      checks++; if (obs_q[ob+i] !== exp[i]) begin errors++; $display("FAIL full_order%0d: got %h want %h", i, obs_q[ob+i], exp[i]); end
    end
    checks++; if (wr_count !== 16'd5 || fifo_level !== 3'd0) begin errors++; $display("FAIL full_final: count %0d level %0d want 5/0", wr_count, fifo_level); end
  endtask

  task automatic test_stall();
    packet_t p;
    apply_reset();
    bif.ready = 1'b0;
    p = packet_t'({$urandom, 16'($urandom)});
    pkt_valid = 1'b1; pkt_in = p;
    @(negedge clk);
    pkt_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < STALL_CHECK; k++) begin
      checks++; if (bif.valid !== 1'b1 || bif.write_enable !== 1'b1 || bif.addr !== p.id || bif.data !== p.data || timeout_err !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d: v%0b we%0b %h/%h terr%0b want 1/1 %h/%h 0", k, bif.valid, bif.write_enable, bif.addr, bif.data, timeout_err, p.id, p.data); end
      @(negedge clk);
    end
    bif.ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL stall_count: got %0d want 1", wr_count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bif.ready = 1'b1;
    pkt_valid = 1'b1; pkt_in = packet_t'({32'h1, 16'h1});
    @(negedge clk);
    pkt_valid = 1'b0;
    repeat (3) @(negedge clk);
    bif.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pkt_valid = 1'b1; pkt_in = packet_t'({32'(i + 16), 16'($urandom)});
      @(negedge clk);
    end
    pkt_valid = 1'b0;
    checks++; if (bif.valid !== 1'b1 || wr_count !== 16'd1 || fifo_level !== 3'd2) begin errors++; $display("FAIL midrst_pre: valid %0b count %0d level %0d want 1/1/2", bif.valid, wr_count, fifo_level); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bif.valid !== 1'b0 || bif.write_enable !== 1'b0) begin errors++; $display("FAIL midrst_valid: v%0b we%0b want 0/0", bif.valid, bif.write_enable); end
    checks++; if (fifo_level !== 3'd0 || wr_count !== 16'd0) begin errors++; $display("FAIL midrst_state: level %0d count %0d want 0/0", fifo_level, wr_count); end
    @(negedge clk);
    rst = 1'b0;
    bif.ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bif.valid !== 1'b0 || wr_count !== 16'd0) begin errors++; $display("FAIL midrst_after: valid %0b count %0d want 0/0", bif.valid, wr_count); end
  endtask

`ifdef PKT_BUS_WRITER_TIMEOUT_EN
  task automatic test_timeout();
    packet_t p0;
    packet_t p1;
    int ob;
    int tb0;
    apply_reset();
    ob = obs_q.size(); tb0 = tmo_pulses;
    bif.ready = 1'b0;
    p0 = packet_t'({$urandom, 16'($urandom)});
    p1 = packet_t'({$urandom, 16'($urandom)});
    pkt_valid = 1'b1; pkt_in = p0;
    @(negedge clk);
    pkt_in = p1;
    @(negedge clk);
    pkt_valid = 1'b0;
    checks++; if (bif.valid !== 1'b1 || bif.addr !== p0.id) begin errors++; $display("FAIL tmo_start: valid %0b addr %h want 1/%h", bif.valid, bif.addr, p0.id); end
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k < TMO) begin
        checks++; if (bif.valid !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early%0d: valid %0b terr %0b want 1/0", k, bif.valid, timeout_err); end
      end else begin
        checks++; if (bif.valid !== 1'b0 || bif.write_enable !== 1'b0 || timeout_err !== 1'b1 || wr_count !== 16'd0)
          begin errors++; $display("FAIL tmo_fire: v%0b we%0b terr%0b count %0d want 0/0/1/0", bif.valid, bif.write_enable, timeout_err, wr_count); end
      end
    end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0 || bif.valid !== 1'b1 || bif.addr !== p1.id) begin errors++; $display("FAIL tmo_resume: terr %0b valid %0b addr %h want 0/1/%h", timeout_err, bif.valid, bif.addr, p1.id); end
    bif.ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() - ob != 1 || wr_count !== 16'd1 || tmo_pulses - tb0 != 1) begin errors++; $display("FAIL tmo_final: writes %0d count %0d pulses %0d want 1/1/1", obs_q.size() - ob, wr_count, tmo_pulses - tb0); end
    if (obs_q.size() > ob) begin
      checks++; if (obs_q[ob] !== p1) begin errors++; $display("FAIL tmo_packet: got %h want %h", obs_q[ob], p1); end
    end
  endtask
`endif

  task automatic test_random();
    int ob;
    int ab;
    int stall_run;
    int n;
    apply_reset();
    ob = obs_q.size(); ab = acc_q.size(); stall_run = 0;
    for (int c = 0; c < 400; c++) begin
      pkt_valid = ($urandom_range(0, 2) != 0);
      pkt_in    = packet_t'({$urandom, 16'($urandom)});
      bif.ready = (stall_run >= 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
      stall_run = bif.ready ? 0 : stall_run + 1;
      @(negedge clk);
    end
    pkt_valid = 1'b0; bif.ready = 1'b1;
    repeat (10) @(negedge clk);
    n = acc_q.size() - ab;
    checks++; if (obs_q.size() - ob != n || n < 50) begin errors++; $display("FAIL rand_count: writes %0d accepted %0d", obs_q.size() - ob, n); end
    for (int i = 0; i < n && ob + i < obs_q.size(); i++) begin
      checks++; if (obs_q[ob+i] !== acc_q[ab+i] || obs_we[ob+i] !== 1'b1) begin errors++; $display("FAIL rand_write%0d: got %h we %0b want %h", i, obs_q[ob+i], obs_we[ob+i], acc_q[ab+i]); end
    end
    checks++; if (wr_count !== 16'(n) || fifo_level !== 3'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rand_final: count %0d level %0d terr %0b want %0d/0/0", wr_count, fifo_level, timeout_err, n); end
  endtask

  initial begin
    bif.ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_stall();
    test_reset_mid();
`ifdef PKT_BUS_WRITER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
